// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch, data and debug requesters.
// Define MEM_ARB_DBG_EN to enable the debug port and its burst limiter.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int RAM_SIZE  = 4096,
  parameter int DBG_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_req,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_gnt,
  output logic                          if_rvalid,
  output logic [31:0]                   if_rdata,
  input  logic                          dm_req,
  input  logic                          dm_we,
  input  logic [3:0]                    dm_be,
  input  logic [ADDR_W-1:0]             dm_addr,
  input  logic [31:0]                   dm_wdata,
  output logic                          dm_gnt,
  output logic                          dm_rvalid,
  output logic [31:0]                   dm_rdata,
  input  logic                          dbg_req,
  input  logic                          dbg_we,
  input  logic [ADDR_W-1:0]             dbg_addr,
  input  logic [31:0]                   dbg_wdata,
  output logic                          dbg_gnt,
  output logic                          dbg_rvalid,
  output logic [31:0]                   dbg_rdata,
  output logic                          mem_en,
  output logic [3:0]                    mem_we,
  output logic [$clog2(RAM_SIZE)-3:0]   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  output logic                          err
);

  localparam int AW = $clog2(RAM_SIZE);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM,
    OWN_DBG
  } own_t;

  own_t              own_q;
  own_t              own_d;
  logic              flt_q;
  logic              err_q;
  logic              last_dm;
  logic              cpu_req;
  logic              dbg_win;
  logic              if_win;
  logic              dm_win;
  logic              any_win;
  logic              rd_win;
  logic              fault;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic [31:0]       rd_val;

  assign cpu_req = if_req | dm_req;

`ifdef MEM_ARB_DBG_EN
  localparam int CW = $clog2(DBG_BURST + 1);

  logic [CW-1:0] dbg_cnt;
  logic          dbg_block;

  assign dbg_block = (dbg_cnt == CW'(DBG_BURST)) && cpu_req;
  assign dbg_win   = !rst && dbg_req && !dbg_block;

  // Only debug grants that starve a waiting CPU port count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_cnt <= '0;
    end else if (!dbg_req || if_win || dm_win) begin
      dbg_cnt <= '0;
    end else if (dbg_win && cpu_req) begin
      dbg_cnt <= dbg_cnt + CW'(1);
    end
  end
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_req, dbg_we,
                        dbg_addr, dbg_wdata};
  assign dbg_win    = 1'b0;
`endif

  assign if_win = !rst && !dbg_win && if_req
                  && (!dm_req || last_dm);
  assign dm_win = !rst && !dbg_win && dm_req
                  && (!if_req || !last_dm);

  always_comb begin
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_be    = 4'h0;
    sel_wdata = 32'h0;
    own_d     = OWN_NONE;
    unique case (1'b1)
`ifdef MEM_ARB_DBG_EN
      dbg_win: begin
        sel_addr  = dbg_addr;
        sel_wr    = dbg_we;
        sel_be    = 4'hF;
        sel_wdata = dbg_wdata;
        own_d     = OWN_DBG;
      end
`endif
      dm_win: begin
        sel_addr  = dm_addr;
        sel_wr    = dm_we;
        sel_be    = dm_be;
        sel_wdata = dm_wdata;
        own_d     = OWN_DM;
      end
      if_win: begin
        sel_addr = if_addr;
        own_d    = OWN_IF;
      end
      default: ;
    endcase
  end

  assign any_win = dbg_win | dm_win | if_win;
  assign rd_win  = any_win && !sel_wr;
  assign fault   = (sel_addr[1:0] != 2'b00)
                   || ((sel_addr >> AW) != '0);

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign dbg_gnt   = dbg_win;
  assign mem_en    = any_win && !fault;
  assign mem_we    = (mem_en && sel_wr) ? sel_be : 4'h0;
  assign mem_addr  = sel_addr[AW-1:2];
  assign mem_wdata = sel_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q   <= OWN_NONE;
      flt_q   <= 1'b0;
      err_q   <= 1'b0;
      last_dm <= 1'b1;
    end else begin
      own_q <= rd_win ? own_d : OWN_NONE;
      flt_q <= fault;
      err_q <= any_win && fault;
      if (if_win) begin
        last_dm <= 1'b0;
      end else if (dm_win) begin
        last_dm <= 1'b1;
      end
    end
  end

  // Outputs are held quiet during reset even if a read was in flight.
  assign rd_val    = flt_q ? 32'h0 : mem_rdata;
  assign if_rvalid = !rst && (own_q == OWN_IF);
  assign dm_rvalid = !rst && (own_q == OWN_DM);
  assign if_rdata  = if_rvalid ? rd_val : 32'h0;
  assign dm_rdata  = dm_rvalid ? rd_val : 32'h0;
  assign err       = !rst && err_q;

`ifdef MEM_ARB_DBG_EN
  assign dbg_rvalid = !rst && (own_q == OWN_DBG);
  assign dbg_rdata  = dbg_rvalid ? rd_val : 32'h0;
`else
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction model plus directed vectors.
// Covers both MEM_ARB_DBG_EN builds.
module tb_mem_port_arbiter;

  localparam int RAM_SIZE  = 4096;
  localparam int DBG_BURST = 4;
`ifdef MEM_ARB_DBG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        err;

  int tests;
  int fails;

  mem_port_arbiter #(
    .ADDR_W(32),
    .RAM_SIZE(RAM_SIZE),
    .DBG_BURST(DBG_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: one-cycle registered read.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we[0]) ram[mem_addr][7:0]   <= mem_wdata[7:0];
      if (mem_we[1]) ram[mem_addr][15:8]  <= mem_wdata[15:8];
      if (mem_we[2]) ram[mem_addr][23:16] <= mem_wdata[23:16];
      if (mem_we[3]) ram[mem_addr][31:24] <= mem_wdata[31:24];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference model, checked every cycle.
  logic [31:0] mdl [1024];
  initial begin
    int          w;
    int          pend;
    int          run;
    bit          last_if;
    bit          pend_err;
    logic [31:0] pend_data;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [3:0]  ewe;
    bit          wr;
    bit          flt;
    bit          een;
    bit          cpu;
    bit          v;
    for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
    pend = 0; run = 0; last_if = 1'b0;
    pend_err = 1'b0; pend_data = 32'h0;
    forever begin
      @(negedge clk);
      cpu = if_req || dm_req;
      if (rst) w = 0;
      else if (DBG_EN && dbg_req
               && !(run == DBG_BURST && cpu)) w = 3;
      else if (if_req && dm_req) w = last_if ? 2 : 1;
      else if (if_req) w = 1;
      else if (dm_req) w = 2;
      else w = 0;
      a = 32'h0; wr = 1'b0; be = 4'h0; wd = 32'h0;
      case (w)
        1: a = if_addr;
        2: begin
          a = dm_addr; wr = dm_we;
          be = dm_be; wd = dm_wdata;
        end
        3: begin
          a = dbg_addr; wr = dbg_we;
          be = 4'hF; wd = dbg_wdata;
        end
        default: ;
      endcase
      flt = (w != 0) && ((a % 4) != 0 || a >= RAM_SIZE);
      een = (w != 0) && !flt;
      ewe = (een && wr) ? be : 4'h0;
      chk("m_if_gnt", if_gnt, w == 1);
      chk("m_dm_gnt", dm_gnt, w == 2);
      chk("m_dbg_gnt", dbg_gnt, w == 3);
      chk("m_mem_en", mem_en, een);
      chk("m_mem_we", mem_we, ewe);
      if (een) chk("m_mem_addr", mem_addr, a[11:2]);
      if (ewe != 0) chk("m_mem_wdata", mem_wdata, wd);
      v = !rst && pend == 1;
      chk("m_if_rvalid", if_rvalid, v);
      chk("m_if_rdata", if_rdata, v ? pend_data : 0);
      v = !rst && pend == 2;
      chk("m_dm_rvalid", dm_rvalid, v);
      chk("m_dm_rdata", dm_rdata, v ? pend_data : 0);
      v = !rst && pend == 3;
      chk("m_dbg_rvalid", dbg_rvalid, v);
      chk("m_dbg_rdata", dbg_rdata, v ? pend_data : 0);
      chk("m_err", err, !rst && pend_err);
      pend_data = flt ? 32'h0 : mdl[a[11:2]];
      pend      = (w != 0 && !wr) ? w : 0;
      pend_err  = (w != 0) && flt;
      for (int b = 0; b < 4; b++)
        if (ewe[b]) mdl[a[11:2]][8*b +: 8] = wd[8*b +: 8];
      if (rst) last_if = 1'b0;
      else if (w == 1) last_if = 1'b1;
      else if (w == 2) last_if = 1'b0;
      if (rst || !dbg_req || w == 1 || w == 2) run = 0;
      else if (w == 3 && cpu) run++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] pa [4];
  logic [31:0] pd [4];

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_be = 0;
    dm_addr = 0; dm_wdata = 0;
    dbg_req = 0; dbg_we = 0;
    dbg_addr = 0; dbg_wdata = 0;
    pa[0] = 32'h000; pd[0] = 32'hA0A0_0001;
    pa[1] = 32'h100; pd[1] = 32'hB0B0_0002;
    pa[2] = 32'h040; pd[2] = 32'h1122_3344;
    pa[3] = 32'h104; pd[3] = 32'hC0C0_0003;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    tick();
    rst = 1'b0;

    dm_req = 1; dm_we = 1; dm_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      dm_addr = pa[i]; dm_wdata = pd[i];
      tick();
    end

    dm_we = 0; dm_addr = 32'h100;
    if_req = 1; if_addr = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("alt_if_gnt", if_gnt, (k % 2) == 0);
      chk("alt_dm_gnt", dm_gnt, (k % 2) == 1);
      if (k > 0) begin
        if ((k % 2) == 1) begin
          chk("alt_if_rvalid", if_rvalid, 1);
          chk("alt_if_rdata", if_rdata, 32'hA0A0_0001);
        end else begin
          chk("alt_dm_rvalid", dm_rvalid, 1);
          chk("alt_dm_rdata", dm_rdata, 32'hB0B0_0002);
        end
      end
      tick();
    end
    if_req = 0; dm_req = 0;

    dm_req = 1; dm_we = 1; dm_be = 4'b0011;
    dm_addr = 32'h40; dm_wdata = 32'hAABB_CCDD;
    tick();
    dm_req = 0; dm_we = 0;
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    chk("wr_if_gnt", if_gnt, 1);
    tick();
    if_req = 0;
    @(negedge clk);
    chk("wr_if_rvalid", if_rvalid, 1);
    chk("wr_if_rdata", if_rdata, 32'h1122_CCDD);
    tick();

`ifdef MEM_ARB_DBG_EN
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100;
    if_req = 1; if_addr = 32'h0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("burst_dbg_gnt", dbg_gnt, k != 4);
      chk("burst_if_gnt", if_gnt, k == 4);
      tick();
    end
    if_req = 0;
    dbg_we = 1; dbg_addr = 32'h104;
    dbg_wdata = 32'h5555_AAAA;
    tick();
    dbg_we = 0;
    tick();
    dbg_req = 0;
    @(negedge clk);
    chk("dbg_rvalid", dbg_rvalid, 1);
    chk("dbg_rdata", dbg_rdata, 32'h5555_AAAA);
    tick();
`else
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h100;
    dbg_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("nodbg_gnt", dbg_gnt, 0);
      chk("nodbg_mem_en", mem_en, 0);
      tick();
    end
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    @(negedge clk);
    chk("nodbg_dm_gnt", dm_gnt, 1);
    tick();
    dm_req = 0;
    @(negedge clk);
    chk("nodbg_dm_rdata", dm_rdata, 32'hB0B0_0002);
    chk("nodbg_dbg_rvalid", dbg_rvalid, 0);
    tick();
    dbg_req = 0; dbg_we = 0;
`endif

    dm_req = 1; dm_we = 0; dm_addr = 32'h102;
    @(negedge clk);
    chk("f1_dm_gnt", dm_gnt, 1);
    chk("f1_mem_en", mem_en, 0);
    chk("f1_err", err, 0);
    tick();
    dm_addr = RAM_SIZE;
    @(negedge clk);
    chk("f2_dm_gnt", dm_gnt, 1);
    chk("f2_mem_en", mem_en, 0);
    chk("f1_err_pulse", err, 1);
    chk("f1_dm_rvalid", dm_rvalid, 1);
    chk("f1_dm_rdata", dm_rdata, 0);
    tick();
    dm_req = 0;
    @(negedge clk);
    chk("f2_err_pulse", err, 1);
    chk("f2_dm_rvalid", dm_rvalid, 1);
    chk("f2_dm_rdata", dm_rdata, 0);
    tick();
    @(negedge clk);
    chk("f_err_clear", err, 0);
    tick();
    dm_req = 1; dm_we = 1; dm_be = 4'hF;
    dm_addr = 32'h203; dm_wdata = 32'h0;
    @(negedge clk);
    chk("fw_mem_we", mem_we, 0);
    tick();
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    chk("fw_err", err, 1);
    chk("fw_dm_rvalid", dm_rvalid, 0);
    tick();

    if_req = 1; if_addr = 32'h0;
    @(negedge clk);
    chk("pre_rst_if_gnt", if_gnt, 1);
    tick();
    rst = 1; if_req = 0; dm_req = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_rst_if_rvalid", if_rvalid, 0);
      chk("mid_rst_if_rdata", if_rdata, 0);
      chk("mid_rst_dm_gnt", dm_gnt, 0);
      chk("mid_rst_mem_en", mem_en, 0);
      chk("mid_rst_err", err, 0);
      tick();
    end
    rst = 0; if_req = 1; dm_req = 1; dm_we = 0;
    @(negedge clk);
    chk("post_rst_if_gnt", if_gnt, 1);
    chk("post_rst_dm_gnt", dm_gnt, 0);
    chk("post_rst_if_rvalid", if_rvalid, 0);
    tick();
    if_req = 0; dm_req = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
